if_fetch_ctrl: RTL
==================

// Module: if_fetch_ctrl
// PURPOSE
//  Instruction-fetch stage controller; sits directly upstream of the IF/ID pipeline register.
//  Owns the PC, selects the next PC (sequential, branch, jump), and drives the imem address.
//  Feeds IF/ID with {pc+4, instruction} and its enable; squashes the wrong-path fetch with a NOP.
//  Freezes fetch for a fixed number of cycles while the iterative multiplier runs.
// PARAMETERS
//  RESET_PC          32'h0000_0000  PC value loaded on reset
//  MUL_STALL_CYCLES  32             fetch-freeze length per multiply, legal range 1..255
//  NOP_INSN          32'h0000_0000  instruction word injected on a squash
// PORTS
//  clk            in   1   rising-edge clock
//  rst            in   1   reset, asynchronous, active-high
//  stall_hazard   in   1   load-use stall request from the hazard unit
//  mul_start      in   1   one-cycle pulse: ID has decoded a multiply
//  branch_taken   in   1   taken branch resolved this cycle
//  branch_target  in   32  branch destination
//  jump           in   1   jump resolved this cycle
//  jump_target    in   32  jump destination
//  imem_rdata     in   32  combinational instruction-memory read data for imem_addr
//  imem_addr      out  32  current PC, the fetch address
//  pc_next_seq    out  32  imem_addr + 4, goes to IF/ID pc_in
//  ins_to_ifid    out  32  imem_rdata, or NOP_INSN when squashing; goes to IF/ID ins_in
//  ifid_en        out  1   IF/ID load enable (en_reg)
//  mul_busy       out  1   high while the multiply freeze is active
//  mul_done       out  1   one-cycle pulse when the freeze ends
// BEHAVIOUR
//  Reset, asynchronous: pc=RESET_PC; state=RUN; cnt=0; pending redirect cleared; mul_busy=0; mul_done=0.
//   Combinational outputs are then imem_addr=RESET_PC and ifid_en=1.
//  FSM states: RUN and MUL_WAIT. cnt is 8 bits wide. pc+4 wraps modulo 2^32.
//  Redirect: jump has priority over branch_taken (tgt=jump_target when both are high).
//   Each redirect target is 4-byte aligned; bits [1:0] of the target are forced to 0.
//  RUN, evaluated in this priority order each cycle:
//   1 mul_start=1:
//     - next state MUL_WAIT, cnt<=0, pc held.
//     - A redirect in the same cycle is latched as pending (pend_v<=1, pend_pc<=tgt).
//     - ifid_en=0.
//   2 else pend_v=1:
//     - pc<=pend_pc, pend_v<=0.
//     - ifid_en=1, ins_to_ifid=NOP_INSN.
//     - A new redirect in this same cycle overrides pend_pc.
//   3 else redirect:
//     - pc<=tgt.
//     - ifid_en=1, ins_to_ifid=NOP_INSN (squash the wrong-path fetch).
//   4 else stall_hazard=1: pc held, ifid_en=0.
//   5 else: pc<=pc+4, ifid_en=1, ins_to_ifid=imem_rdata.
//  MUL_WAIT:
//   - ifid_en=0 and pc held.
//   - mul_start is ignored; stall_hazard is ignored.
//   - cnt<=cnt+1 each cycle.
//   - A redirect sets pend_v/pend_pc; the last one received wins.
//   - When cnt==MUL_STALL_CYCLES-1: next state RUN, cnt<=0.
//  mul_busy is registered. It is high for exactly MUL_STALL_CYCLES cycles, starting the cycle after mul_start.
//  mul_done is registered. It pulses once, in the first RUN cycle after the freeze.
//   A pending redirect is applied in that same cycle (rule 2).
//  Reset asserted mid-freeze aborts the freeze immediately. mul_busy=0, no mul_done pulse, pending redirect dropped.
// TESTING
//  T1 reset: assert rst, RESET_PC=0 -> imem_addr=0, mul_busy=0, mul_done=0, ifid_en=1; release -> PCs 0,4,8,C.
//  T2 stall_hazard high for 2 cycles at pc=8 -> imem_addr stays 8 for 2 cycles, ifid_en=0; then 0xC.
//  T3 at pc=0x10: jump=1 (0x40) + branch_taken=1 (0x80) -> ins_to_ifid=NOP, next pc=0x40, pc_next_seq=0x44.
//  T4 mul_start at pc=0x20, MUL_STALL_CYCLES=32:
//     - mul_busy high for 32 cycles, ifid_en=0, pc=0x20 throughout.
//     - mul_done pulses once; then pc=0x24.
//  T5 during freeze: branch_taken to 0x100 on busy cycle 5, then jump to 0x200 on cycle 9
//     -> on exit mul_done=1, NOP injected, next pc=0x200.
//  T6 rst asserted on busy cycle 10 -> pc=RESET_PC, mul_busy=0, no mul_done pulse; normal fetch resumes.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, selects sequential/branch/jump next PC,
// feeds IF/ID with {pc+4, insn} and freezes fetch for a fixed window per multiply.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC         = 32'h0000_0000,
  parameter int          MUL_STALL_CYCLES = 32,
  parameter logic [31:0] NOP_INSN         = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_hazard,
  input  logic        mul_start,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] pc_next_seq,
  output logic [31:0] ins_to_ifid,
  output logic        ifid_en,
  output logic        mul_busy,
  output logic        mul_done
);

  typedef enum logic {RUN, MUL_WAIT} state_t;

  localparam logic [7:0] CNT_LAST = 8'(MUL_STALL_CYCLES - 1);

  state_t      state, state_next;
  logic [7:0]  cnt, cnt_next;
  logic [31:0] pc, pc_next;
  logic        pend_v, pend_v_next;
  logic [31:0] pend_pc, pend_pc_next;
  logic        mul_busy_next, mul_done_next;

  logic        redirect;
  logic [31:0] tgt_raw, tgt;

  // Jump wins over a simultaneous taken branch; targets are word aligned.
  assign redirect = jump | branch_taken;
  assign tgt_raw  = jump ? jump_target : branch_target;
  assign tgt      = {tgt_raw[31:2], 2'b00};

  assign imem_addr   = pc;
  assign pc_next_seq = pc + 32'd4;

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    pc_next      = pc;
    pend_v_next  = pend_v;
    pend_pc_next = pend_pc;
    ifid_en      = 1'b0;
    ins_to_ifid  = imem_rdata;

    case (state)
      RUN: begin
        if (mul_start) begin
          state_next = MUL_WAIT;
          cnt_next   = 8'd0;
          if (redirect) begin
            pend_v_next  = 1'b1;
            pend_pc_next = tgt;
          end
        end else if (pend_v) begin
          // Redirect deferred across the freeze; a fresh one this cycle is newer.
          pc_next      = redirect ? tgt : pend_pc;
          pend_v_next  = 1'b0;
          pend_pc_next = redirect ? tgt : pend_pc;
          ifid_en      = 1'b1;
          ins_to_ifid  = NOP_INSN;
        end else if (redirect) begin
          pc_next     = tgt;
          ifid_en     = 1'b1;
          ins_to_ifid = NOP_INSN;
        end else if (!stall_hazard) begin
          pc_next = pc + 32'd4;
          ifid_en = 1'b1;
        end
      end

      MUL_WAIT: begin
        cnt_next = cnt + 8'd1;
        if (redirect) begin
          pend_v_next  = 1'b1;
          pend_pc_next = tgt;
        end
        if (cnt == CNT_LAST) begin
          state_next = RUN;
          cnt_next   = 8'd0;
        end
      end

      default: begin
        state_next = RUN;
        cnt_next   = 8'd0;
      end
    endcase

    mul_busy_next = (state_next == MUL_WAIT);
    mul_done_next = (state == MUL_WAIT) && (cnt == CNT_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      cnt      <= 8'd0;
      pc       <= RESET_PC;
      pend_v   <= 1'b0;
      pend_pc  <= 32'd0;
      mul_busy <= 1'b0;
      mul_done <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      pc       <= pc_next;
      pend_v   <= pend_v_next;
      pend_pc  <= pend_pc_next;
      mul_busy <= mul_busy_next;
      mul_done <= mul_done_next;
    end
  end

endmodule
